// File: rtl/midi_in_merger.sv
// midi_in_merger: merges NUM_SRC MIDI byte streams through per-source FIFOs and a message-locking round-robin arbiter
module midi_in_merger #(
    parameter int NUM_SRC      = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int OUT_GAP      = 2,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset_reg_N,
    input  logic [NUM_SRC-1:0]         byteready_i,
    input  logic [8*NUM_SRC-1:0]       cur_status_i,
    input  logic [8*NUM_SRC-1:0]       midibyte_nr_i,
    input  logic [8*NUM_SRC-1:0]       midi_in_data_i,
    input  logic [NUM_SRC-1:0]         ovf_clr,
    output logic                       byteready,
    output logic [7:0]                 cur_status,
    output logic [7:0]                 midibyte_nr,
    output logic [7:0]                 midi_in_data,
    output logic [$clog2(NUM_SRC)-1:0] src_id,
    output logic [NUM_SRC-1:0]         ovf,
    output logic                       lock_active
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(NUM_SRC);
    localparam int GW = $clog2(OUT_GAP + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [SW-1:0] LAST     = SW'(NUM_SRC - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(OUT_GAP - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(LOCK_TIMEOUT);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t             r_state, w_state_nxt;
    logic [23:0]        r_mem [NUM_SRC][FIFO_DEPTH];
    logic [PW-1:0]      r_wp [NUM_SRC];
    logic [PW-1:0]      r_rp [NUM_SRC];
    logic [NUM_SRC-1:0] r_ovf;
    logic [SW-1:0]      r_rr, r_lock;
    logic [GW-1:0]      r_gap;
    logic [TW-1:0]      r_to;
    logic [NUM_SRC-1:0] w_empty, w_full, w_wr, w_pop, w_ovf_set;
    logic [SW-1:0]      w_idx, w_sel, w_src;
    logic               w_found, w_go, w_release, w_to_hit, w_lock_empty;
    logic [23:0]        w_head;
    logic [3:0]         w_hi;
    logic [1:0]         w_len;

    // FIFO occupancy flags; the pointer MSB separates full from empty
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_empty[k] = r_wp[k] == r_rp[k];
            w_full[k]  = (r_wp[k][AW-1:0] == r_rp[k][AW-1:0]) && (r_wp[k][AW] != r_rp[k][AW]);
        end
    end

    // A write into a full FIFO is accepted only if that FIFO is popped in the same cycle
    always_comb begin
        w_wr      = '0;
        w_ovf_set = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_wr[k]      = byteready_i[k] && (!w_full[k] || w_pop[k]);
            w_ovf_set[k] = byteready_i[k] && w_full[k] && !w_pop[k];
        end
    end

    // Round-robin pick, head decode and next arbiter state
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = r_rr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && !w_empty[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
            w_idx = (w_idx == LAST) ? '0 : w_idx + SW'(1);
        end
        w_src        = (r_state == S_LOCKED) ? r_lock : w_sel;
        w_lock_empty = (r_state == S_LOCKED) && w_empty[r_lock];
        w_go         = (r_gap == '0) && ((r_state == S_LOCKED) ? !w_empty[r_lock] : w_found);
        w_head       = r_mem[w_src][r_rp[w_src][AW-1:0]];
        w_hi         = w_head[23:20];
        w_len        = (w_hi inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hE}) ? 2'd2 : (w_hi inside {4'hC, 4'hD}) ? 2'd1 : 2'd0;
        w_release    = (w_len == 2'd0) || (w_head[15:8] >= {6'd0, w_len});
        w_to_hit     = w_lock_empty && (r_to == TO_LAST);
        w_pop        = w_go ? NUM_SRC'(1) << w_src : '0;
        w_state_nxt  = (r_state == S_IDLE) ? ((w_go && !w_release) ? S_LOCKED : S_IDLE)
                                           : (((w_go && w_release) || w_to_hit) ? S_IDLE : S_LOCKED);
    end

    // FIFO pointers and sticky overflow flags; a new overflow beats a clear
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                r_wp[k] <= '0;
                r_rp[k] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (w_wr[k]) r_wp[k] <= r_wp[k] + PW'(1);
                if (w_pop[k]) r_rp[k] <= r_rp[k] + PW'(1);
            end
            r_ovf <= w_ovf_set | (r_ovf & ~ovf_clr);
        end
    end

    // FIFO storage of {status, index, data}
    always_ff @(posedge CLOCK_50) begin
        for (int k = 0; k < NUM_SRC; k++)
            if (w_wr[k]) r_mem[k][r_wp[k][AW-1:0]] <= {cur_status_i[8*k +: 8], midibyte_nr_i[8*k +: 8], midi_in_data_i[8*k +: 8]};
    end

    // Arbiter state, lock owner, RR pointer, output gap and lock watchdog
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_state <= S_IDLE;
            r_lock  <= '0;
            r_rr    <= '0;
            r_gap   <= '0;
            r_to    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lock  <= w_go ? w_src : r_lock;
            r_rr    <= (w_go && r_state == S_IDLE) ? ((w_sel == LAST) ? '0 : w_sel + SW'(1)) : r_rr;
            r_gap   <= w_go ? GAP_LOAD : (r_gap != '0) ? r_gap - GW'(1) : r_gap;
            r_to    <= (w_go || w_to_hit || !w_lock_empty) ? '0 : (r_to != TO_MAX) ? r_to + TW'(1) : r_to;
        end
    end

    // Registered merged output; data fields hold between strobes
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            byteready    <= 1'b0;
            cur_status   <= '0;
            midibyte_nr  <= '0;
            midi_in_data <= '0;
            src_id       <= '0;
        end else begin
            byteready <= w_go;
            if (w_go) begin
                {cur_status, midibyte_nr, midi_in_data} <= w_head;
                src_id <= w_src;
            end
        end
    end

    assign ovf         = r_ovf;
    assign lock_active = r_state == S_LOCKED;
endmodule
